// File: rtl/dmem_responder.sv
// dmem_responder: slow data-memory responder for the MEM stage.
// Accepts one read/write over valid/ready, waits WAIT_STATES cycles,
// accesses an internal synchronous RAM, then pulses a one-cycle response.
// Ports:
//   clk_i, rst_i (async, active-high)
//   req_valid_i, req_we_i, req_addr_i, req_wdata_i : request in
//   req_ready_o : high only when idle
//   rsp_valid_o, rsp_rdata_o : one-cycle response, held read data
//   rsp_err_o   : out-of-range flag (only with DMEM_RANGE_CHECK_EN)
//   busy_o      : high from accept until return to idle
// Optional: define DMEM_RANGE_CHECK_EN to reject addresses whose bits
// above DEPTH_LOG2 are nonzero instead of aliasing them.
module dmem_responder #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  req_ready_o,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
`ifdef DMEM_RANGE_CHECK_EN
    output logic                  rsp_err_o,
`endif
    output logic                  busy_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] WS_LD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic                  we_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  oor_q;
    logic                  oor_in;
    logic                  accept;
    logic                  mem_we;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign accept = req_valid_i && req_ready_o;

`ifdef DMEM_RANGE_CHECK_EN
    // Any set bit above the RAM index marks the request out of range.
    assign oor_in = (req_addr_i >> DEPTH_LOG2) != '0;
`else
    // Upper address bits alias onto the RAM; they are deliberately unused.
    logic addr_hi_unused;
    assign addr_hi_unused = |(req_addr_i >> DEPTH_LOG2);
    assign oor_in = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    state_d = ST_WAIT;
                    cnt_d   = WS_LD;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign rsp_valid_o = (state_q == ST_RESP);
`ifdef DMEM_RANGE_CHECK_EN
    assign rsp_err_o   = (state_q == ST_RESP) && oor_q;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture: inputs are ignored after the accept edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            oor_q   <= 1'b0;
        end else if (accept) begin
            we_q    <= req_we_i;
            idx_q   <= req_addr_i[DEPTH_LOG2-1:0];
            wdata_q <= req_wdata_i;
            oor_q   <= oor_in;
        end
    end

    assign mem_we = (state_q == ST_ACCESS) && we_q && !oor_q;

    // RAM contents survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    // Read data is registered on the access edge and held until the next.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_rdata_o <= '0;
        end else if (state_q == ST_ACCESS) begin
            if (we_q || oor_q) begin
                rsp_rdata_o <= '0;
            end else begin
                rsp_rdata_o <= mem[idx_q];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder.
// Three instances: WAIT_STATES 1, 0 and 3.
module tb_dmem_responder;

    logic        clk;
    logic        rst       [3];
    logic        req_valid [3];
    logic        req_we    [3];
    logic [15:0] req_addr  [3];
    logic [15:0] req_wdata [3];
    logic        req_ready [3];
    logic        rsp_valid [3];
    logic [15:0] rsp_rdata [3];
    logic        rsp_err   [3];
    logic        busy      [3];

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WSV = (g == 0) ? 1 : (g == 1) ? 0 : 3;
        dmem_responder #(.WAIT_STATES(WSV)) u_dut (
            .clk_i       (clk),
            .rst_i       (rst[g]),
            .req_valid_i (req_valid[g]),
            .req_we_i    (req_we[g]),
            .req_addr_i  (req_addr[g]),
            .req_wdata_i (req_wdata[g]),
            .req_ready_o (req_ready[g]),
            .rsp_valid_o (rsp_valid[g]),
            .rsp_rdata_o (rsp_rdata[g]),
`ifdef DMEM_RANGE_CHECK_EN
            .rsp_err_o   (rsp_err[g]),
`endif
            .busy_o      (busy[g])
        );
`ifndef DMEM_RANGE_CHECK_EN
        assign rsp_err[g] = 1'b0;
`endif
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic xact(input int u, input logic we,
                        input logic [15:0] a, input logic [15:0] d,
                        input bit wiggle,
                        output logic [15:0] rd, output int edges,
                        output logic err, output logic linger);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready[u] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        req_valid[u] = 1'b1;
        req_we[u]    = we;
        req_addr[u]  = a;
        req_wdata[u] = d;
        @(negedge clk);
        req_valid[u] = 1'b0;
        edges = 0;
        while (!rsp_valid[u] && edges < 40) begin
            if (wiggle) begin
                req_addr[u]  = 16'h0021 + 16'(edges % 3);
                req_wdata[u] = 16'($urandom);
            end
            @(negedge clk);
            edges++;
        end
        rd  = rsp_rdata[u];
        err = rsp_err[u];
        @(negedge clk);
        linger = rsp_valid[u];
    endtask

    task automatic test_reset();
        for (int u = 0; u < 3; u++) begin
            n_cmp += 4;
            if (req_ready[u] !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_ready[%0d]: got %b want 1", u, req_ready[u]);
            end
            if (busy[u] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_busy[%0d]: got %b want 0", u, busy[u]);
            end
            if (rsp_valid[u] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_rsp_valid[%0d]: got %b want 0", u, rsp_valid[u]);
            end
            if (rsp_rdata[u] !== 16'h0000) begin
                n_bad++;
                $display("FAIL reset_rdata[%0d]: got %h want 0000", u, rsp_rdata[u]);
            end
        end
    endtask

    task automatic test_write_read();
        logic [15:0] rd;
        int lat;
        logic err, lg;
        xact(0, 1'b1, 16'h0005, 16'hBEEF, 0, rd, lat, err, lg);
        n_cmp += 3;
        if (lat !== 3) begin
            n_bad++;
            $display("FAIL wr_latency: got %0d want 3", lat);
        end
        if (rd !== 16'h0000) begin
            n_bad++;
            $display("FAIL wr_rdata: got %h want 0000", rd);
        end
        if (lg !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_pulse_width: got %b want 0", lg);
        end
        xact(0, 1'b0, 16'h0005, 16'h0000, 0, rd, lat, err, lg);
        n_cmp += 4;
        if (lat !== 3) begin
            n_bad++;
            $display("FAIL rd_latency: got %0d want 3", lat);
        end
        if (rd !== 16'hBEEF) begin
            n_bad++;
            $display("FAIL rd_data: got %h want beef", rd);
        end
        if (lg !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_pulse_width: got %b want 0", lg);
        end
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_err: got %b want 0", err);
        end
        xact(0, 1'b1, 16'h0006, 16'h0001, 0, rd, lat, err, lg);
        n_cmp++;
        if (rd !== 16'h0000) begin
            n_bad++;
            $display("FAIL wr_after_rd_rdata: got %h want 0000", rd);
        end
        if (rsp_rdata[0] !== 16'h0000) begin
            n_bad++;
            $display("FAIL wr_rdata_hold: got %h want 0000", rsp_rdata[0]);
        end
        n_cmp++;
    endtask

    task automatic test_alias();
        logic [15:0] rd;
        int lat;
        logic err, lg;
        xact(0, 1'b0, 16'h0405, 16'h0000, 0, rd, lat, err, lg);
`ifdef DMEM_RANGE_CHECK_EN
        n_cmp += 3;
        if (rd !== 16'h0000) begin
            n_bad++;
            $display("FAIL oor_rd_data: got %h want 0000", rd);
        end
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL oor_rd_err: got %b want 1", err);
        end
        if (lat !== 3) begin
            n_bad++;
            $display("FAIL oor_latency: got %0d want 3", lat);
        end
        xact(0, 1'b1, 16'h0405, 16'h1357, 0, rd, lat, err, lg);
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL oor_wr_err: got %b want 1", err);
        end
        xact(0, 1'b0, 16'h0005, 16'h0000, 0, rd, lat, err, lg);
        n_cmp += 2;
        if (rd !== 16'hBEEF) begin
            n_bad++;
            $display("FAIL oor_wr_suppressed: got %h want beef", rd);
        end
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL inrange_err: got %b want 0", err);
        end
`else
        n_cmp += 2;
        if (rd !== 16'hBEEF) begin
            n_bad++;
            $display("FAIL alias_rd_data: got %h want beef", rd);
        end
        if (lat !== 3) begin
            n_bad++;
            $display("FAIL alias_latency: got %0d want 3", lat);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [15:0] rd;
        logic [15:0] exp_d [4];
        int lat, cyc, nacc, nrsp;
        int acc_cyc [4];
        logic err, lg;
        exp_d[0] = 16'h1111;
        exp_d[1] = 16'h2222;
        exp_d[2] = 16'h3333;
        exp_d[3] = 16'h4444;
        for (int i = 0; i < 4; i++) begin
            xact(0, 1'b1, 16'(i), exp_d[i], 0, rd, lat, err, lg);
        end
        cyc  = 0;
        nacc = 0;
        nrsp = 0;
        req_we[0] = 1'b0;
        while (nrsp < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            n_cmp++;
            if (req_ready[0] !== !busy[0]) begin
                n_bad++;
                $display("FAIL b2b_ready_vs_busy: ready %b busy %b", req_ready[0], busy[0]);
            end
            if (rsp_valid[0]) begin
                n_cmp++;
                if (rsp_rdata[0] !== exp_d[nrsp]) begin
                    n_bad++;
                    $display("FAIL b2b_data[%0d]: got %h want %h", nrsp, rsp_rdata[0], exp_d[nrsp]);
                end
                nrsp++;
            end
            if (req_ready[0] && nacc < 4) begin
                req_valid[0] = 1'b1;
                req_addr[0]  = 16'(nacc);
                acc_cyc[nacc] = cyc;
                nacc++;
            end else if (!req_ready[0] && nacc == 4) begin
                req_valid[0] = 1'b0;
            end
        end
        req_valid[0] = 1'b0;
        n_cmp++;
        if (nrsp !== 4) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d want 4", nrsp);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (i + 1 < nacc && acc_cyc[i+1] - acc_cyc[i] !== 5) begin
                n_bad++;
                $display("FAIL b2b_spacing[%0d]: got %0d want 5", i, acc_cyc[i+1] - acc_cyc[i]);
            end else if (i + 1 >= nacc) begin
                n_bad++;
                $display("FAIL b2b_spacing[%0d]: got no accept want 5", i);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_wait0();
        logic [15:0] rd;
        int lat;
        logic err, lg;
        xact(1, 1'b1, 16'h0010, 16'h00AA, 0, rd, lat, err, lg);
        xact(1, 1'b0, 16'h0010, 16'h0000, 0, rd, lat, err, lg);
        n_cmp += 3;
        if (lat !== 2) begin
            n_bad++;
            $display("FAIL ws0_latency: got %0d want 2", lat);
        end
        if (rd !== 16'h00AA) begin
            n_bad++;
            $display("FAIL ws0_data: got %h want 00aa", rd);
        end
        if (lg !== 1'b0) begin
            n_bad++;
            $display("FAIL ws0_pulse_width: got %b want 0", lg);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] rd;
        int lat;
        logic err, lg, seen;
        xact(2, 1'b1, 16'h0007, 16'h5555, 0, rd, lat, err, lg);
        xact(2, 1'b0, 16'h0007, 16'h0000, 0, rd, lat, err, lg);
        n_cmp += 2;
        if (lat !== 5) begin
            n_bad++;
            $display("FAIL ws3_latency: got %0d want 5", lat);
        end
        if (rd !== 16'h5555) begin
            n_bad++;
            $display("FAIL ws3_data: got %h want 5555", rd);
        end
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_addr[2]  = 16'h0007;
        req_wdata[2] = 16'h1234;
        @(negedge clk);
        req_valid[2] = 1'b0;
        @(negedge clk);
        rst[2] = 1'b1;
        #1;
        n_cmp += 4;
        if (req_ready[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_ready: got %b want 1", req_ready[2]);
        end
        if (busy[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_busy: got %b want 0", busy[2]);
        end
        if (rsp_valid[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_rsp_valid: got %b want 0", rsp_valid[2]);
        end
        if (rsp_rdata[2] !== 16'h0000) begin
            n_bad++;
            $display("FAIL midrst_rdata: got %h want 0000", rsp_rdata[2]);
        end
        @(negedge clk);
        rst[2] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid[2]) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_no_rsp: got %b want 0", seen);
        end
        xact(2, 1'b0, 16'h0007, 16'h0000, 0, rd, lat, err, lg);
        n_cmp++;
        if (rd !== 16'h5555) begin
            n_bad++;
            $display("FAIL midrst_write_dropped: got %h want 5555", rd);
        end
    endtask

    task automatic test_addr_change();
        logic [15:0] rd;
        logic [15:0] exp_d [4];
        int lat;
        logic err, lg;
        exp_d[0] = 16'h00FF;
        exp_d[1] = 16'hA001;
        exp_d[2] = 16'hA002;
        exp_d[3] = 16'hA003;
        for (int i = 1; i < 4; i++) begin
            xact(0, 1'b1, 16'h0020 + 16'(i), exp_d[i], 0, rd, lat, err, lg);
        end
        xact(0, 1'b1, 16'h0020, 16'h00FF, 1, rd, lat, err, lg);
        for (int i = 0; i < 4; i++) begin
            xact(0, 1'b0, 16'h0020 + 16'(i), 16'h0000, 0, rd, lat, err, lg);
            n_cmp++;
            if (rd !== exp_d[i]) begin
                n_bad++;
                $display("FAIL latch_addr[%0d]: got %h want %h", i, rd, exp_d[i]);
            end
        end
        xact(0, 1'b0, 16'h0000, 16'h0000, 0, rd, lat, err, lg);
        n_cmp++;
        if (rd !== 16'h1111) begin
            n_bad++;
            $display("FAIL latch_other: got %h want 1111", rd);
        end
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            rst[u]       = 1'b1;
            req_valid[u] = 1'b0;
            req_we[u]    = 1'b0;
            req_addr[u]  = 16'h0000;
            req_wdata[u] = 16'h0000;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) rst[u] = 1'b0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_alias();
        test_back_to_back();
        test_wait0();
        test_reset_mid();
        test_addr_change();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder side of the data-memory request interface driven by the pipeline MEM stage.
- Accepts one read or write request at a time over a valid/ready handshake.
- Inserts a configurable number of wait states, performs the access on an internal synchronous RAM, then returns a single-cycle response (read data or write acknowledge).
- Used to model slow data memory so that MEM-stage stall logic can be exercised.

Parameters:
- DATA_WIDTH, 16, width of data words.
- ADDR_WIDTH, 16, width of the request address.
- DEPTH_LOG2, 10, log2 of the RAM depth in words; must be <= ADDR_WIDTH.
- WAIT_STATES, 1, extra cycles inserted before the access; legal range 0..15.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  request present.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_WIDTH  word address.
- req_wdata_i  in  DATA_WIDTH  write data.
- req_ready_o  out  1  responder can accept a request this cycle.
- rsp_valid_o  out  1  one-cycle response strobe.
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for write responses.
- busy_o  out  1  high from the accept edge until the return to IDLE.

Behaviour:
- Reset values: state IDLE, wait counter 0, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, busy_o=0. RAM contents are not reset.
- Handshake: a request is accepted on a rising edge where req_valid_i && req_ready_o. On accept, we/addr/wdata are latched; later changes on the inputs are ignored.
- req_ready_o=1 only in IDLE (combinational from state).
- busy_o = (state != IDLE).
- FSM states: IDLE, WAIT, ACCESS, RESP.
  - IDLE: on accept -> WAIT, counter loaded with WAIT_STATES.
  - WAIT: if counter==0 -> ACCESS; else counter decrements by 1.
  - ACCESS: on this edge, a write commits to RAM, or the RAM read data is registered into rsp_rdata_o. -> RESP.
  - RESP: rsp_valid_o=1 for exactly this cycle. -> IDLE.
- Latency: rsp_valid_o is high in the cycle beginning WAIT_STATES+2 edges after the accept edge.
- Throughput: one request per WAIT_STATES+4 cycles.
- rsp_rdata_o holds its value until the next RESP. It is driven to 0 in the ACCESS edge of a write.
- Addressing: the RAM index is req_addr_i[DEPTH_LOG2-1:0]. Upper bits are ignored (aliasing), unless the optional feature is enabled.
- Read-after-write: the write commits before the next accept, so a following read to the same address returns the new data.
- A requester holding req_valid_i high continuously gets back-to-back service; the next request is accepted at the first edge in IDLE.
- Reset mid-operation (any non-IDLE state): return to IDLE immediately. A write not yet in ACCESS is dropped, with no RAM update and no response.

Optional Feature:
- Macro DMEM_RANGE_CHECK_EN.
- When defined:
  - Adds output port rsp_err_o (1 bit, reset 0).
  - Any request with a nonzero req_addr_i[ADDR_WIDTH-1:DEPTH_LOG2] still runs the full handshake and latency.
  - Such a write is suppressed. Such a read returns rsp_rdata_o=0.
  - rsp_err_o=1 only in the RESP cycle of such a request.
- When undefined: port absent; out-of-range addresses alias as above.

Test Plan:
- Defaults, write 0xBEEF to 0x0005, then read 0x0005 -> read rsp_valid_o 3 edges after accept, rsp_rdata_o=0xBEEF; write response rdata=0.
- req_valid_i held high with 4 reads to 0x0000..0x0003 preloaded 0x1111..0x4444 -> req_ready_o low while busy; accepts every 5 cycles; data in order.
- WAIT_STATES=0: read 0x0010 holding 0x00AA -> rsp_valid_o 2 edges after accept, rdata 0x00AA.
- Read 0x0405 after writing 0xBEEF to 0x0005, macro undefined -> 0xBEEF (alias). Macro defined -> rdata 0, rsp_err_o=1, and a write to 0x0405 leaves 0x0005 at 0xBEEF.
- Write 0x1234 to 0x0007 (old 0x5555, WAIT_STATES=3), assert rst_i during WAIT -> no rsp_valid_o; outputs at reset values; subsequent read of 0x0007 returns 0x5555.
- Change req_addr_i and req_wdata_i every cycle after an accepted write of 0x00FF to 0x0020 -> 0x0020 holds 0x00FF; no other address modified.
